// File: rtl/vga_grid_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_grid_capture_pkg
//  Description : Shared VGA timing constants, capture FSM states and the
//                cell-index helper used by the capture block and the display
//                that feeds it.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_grid_capture_pkg;

    // Horizontal / vertical position of the first active pixel / line.
    localparam int H_VIDEO_BEGIN = 144;
    localparam int V_VIDEO_BEGIN = 35;

    // Blanking overhead added to the active area to give full line/frame.
    localparam int H_BLANK_TOTAL = 160;
    localparam int V_BLANK_TOTAL = 45;

    // Width of the column and row counters (saturate at all-ones).
    localparam int CNT_W = 10;

    typedef enum logic [0:0] {
        ACQUIRE = 1'b0,
        CAPTURE = 1'b1
    } cap_state_e;

    function automatic int total_col(input int width);
        return width + H_BLANK_TOTAL;
    endfunction

    function automatic int total_row(input int height);
        return height + V_BLANK_TOTAL;
    endfunction

    // Bit position of cell (x,y) in the flattened grid.
    function automatic int idx(input int y, input int x, input int cols);
        return y * cols + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Registers one sync input and flags the first registered
//                cycle at which it is low after having been high.
//  Ports       : clk      - pixel clock
//                rst      - asynchronous active-high reset
//                sig_in   - raw sync input (active low)
//                fall_out - high for one cycle on the registered falling edge
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic fall_out
);

    logic sig_q;
    logic sig_d;
    logic prev_q;
    logic prev_d;

    always_comb begin
        sig_d  = sig_in;
        prev_d = sig_q;
    end

    // Both stages reset low so that a sync already high at release does not
    // produce a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign fall_out = prev_q & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/vga_grid_capture.sv
`default_nettype none
// ============================================================================
//  Module      : vga_grid_capture
//  Description : Recovers a cellular grid from a VGA pixel stream by sampling
//                the centre pixel of every cell; publishes a frame only when
//                its line and frame timing were clean.
//  Ports       : clk, rst            - pixel clock, async active-high reset
//                hsync, vsync        - VGA syncs, low during the pulse
//                r_in, g_in, b_in    - 4-bit pixel colour
//                state_out           - grid, bit y*MAX_X+x = cell (x,y) alive
//                frame_valid         - one-cycle pulse when state_out updates
//                sync_error          - last frame had bad timing
//                locked              - a clean frame was captured since reset
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_grid_capture #(
    parameter int DISPLAY_WIDTH  = 640,
    parameter int DISPLAY_HEIGHT = 480,
    parameter int S_WIDTH        = 10,
    parameter int MAX_X          = DISPLAY_WIDTH / S_WIDTH,
    parameter int MAX_Y          = DISPLAY_HEIGHT / S_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hsync,
    input  logic                     vsync,
    input  logic [3:0]               r_in,
    input  logic [3:0]               g_in,
    input  logic [3:0]               b_in,
    output logic [0:MAX_X*MAX_Y-1]   state_out,
    output logic                     frame_valid,
    output logic                     sync_error,
    output logic                     locked
);

    import vga_grid_capture_pkg::*;

    localparam int N_CELLS = MAX_X * MAX_Y;
    localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int XW      = $clog2(MAX_X + 1);
    localparam int YW      = $clog2(MAX_Y + 1);

    typedef logic [CNT_W:0] ext_t;

    localparam ext_t            TOTAL_COL = ext_t'(total_col(DISPLAY_WIDTH));
    localparam ext_t            TOTAL_ROW = ext_t'(total_row(DISPLAY_HEIGHT));
    // RGB trails the source counters by one cycle, hence the +1 on columns.
    localparam ext_t            COL_FIRST = ext_t'(H_VIDEO_BEGIN + 1 + S_WIDTH / 2);
    localparam ext_t            ROW_FIRST = ext_t'(V_VIDEO_BEGIN + S_WIDTH / 2);
    localparam ext_t            STEP      = ext_t'(S_WIDTH);
    localparam logic [XW-1:0]   MAX_X_V   = XW'(MAX_X);
    localparam logic [YW-1:0]   MAX_Y_V   = YW'(MAX_Y);

    logic                 w_hs_fall;
    logic                 w_vs_fall;

    logic [11:0]          rgb_q, rgb_d;
    logic [CNT_W-1:0]     col_q, col_d;
    logic [CNT_W-1:0]     row_q, row_d;
    ext_t                 next_col_q, next_col_d;
    ext_t                 next_row_q, next_row_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic                 vs_pend_q, vs_pend_d;
    logic                 line_seen_q, line_seen_d;
    logic                 err_q, err_d;
    cap_state_e           state_q, state_d;
    logic [0:N_CELLS-1]   shadow_q, shadow_d;
    logic [0:N_CELLS-1]   grid_q, grid_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_error_q, sync_error_d;
    logic                 locked_q, locked_d;

    logic                 w_row_restart;
    logic                 w_samp_col;
    logic                 w_samp_row;
    logic                 w_line_bad;
    logic                 w_frame_bad;
    logic                 w_err_line;
    logic [IDX_W-1:0]     w_idx;

    sync_edge_det u_hs_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (hsync),
        .fall_out (w_hs_fall)
    );

    sync_edge_det u_vs_edge (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (vsync),
        .fall_out (w_vs_fall)
    );

    assign w_idx = IDX_W'(idx(int'(y_q), int'(x_q), MAX_X));

    always_comb begin
        rgb_d         = {r_in, g_in, b_in};
        col_d         = col_q;
        row_d         = row_q;
        next_col_d    = next_col_q;
        next_row_d    = next_row_q;
        x_d           = x_q;
        y_d           = y_q;
        vs_pend_d     = vs_pend_q;
        line_seen_d   = line_seen_q;
        state_d       = state_q;
        shadow_d      = shadow_q;
        grid_d        = grid_q;
        frame_valid_d = 1'b0;
        sync_error_d  = sync_error_q;
        locked_d      = locked_q;

        // A vsync fall is remembered until the next hsync fall so the row
        // counter restarts on the first line boundary of the new frame.
        w_row_restart = w_hs_fall & (w_vs_fall | vs_pend_q);

        if (w_hs_fall) begin
            col_d = '0;
        end else if (col_q != '1) begin
            col_d = col_q + 1'b1;
        end

        if (w_hs_fall) begin
            if (w_row_restart) begin
                row_d = '0;
            end else if (row_q != '1) begin
                row_d = row_q + 1'b1;
            end
        end

        if (w_vs_fall) begin
            vs_pend_d = 1'b1;
        end
        if (w_hs_fall) begin
            vs_pend_d = 1'b0;
        end

        // Sample points are tracked with running targets instead of a
        // divide/modulo on the counters.
        w_samp_col = ({1'b0, col_d} == next_col_q) && (x_q < MAX_X_V);
        w_samp_row = ({1'b0, row_d} == next_row_q) && (y_q < MAX_Y_V);

        if (w_hs_fall) begin
            x_d         = '0;
            next_col_d  = COL_FIRST;
            line_seen_d = 1'b1;
            if (w_row_restart) begin
                y_d        = '0;
                next_row_d = ROW_FIRST;
            end else if (({1'b0, row_q} == next_row_q) && (y_q < MAX_Y_V)) begin
                y_d        = y_q + 1'b1;
                next_row_d = next_row_q + STEP;
            end
        end else if (w_samp_col) begin
            x_d        = x_q + 1'b1;
            next_col_d = next_col_q + STEP;
            if (w_samp_row) begin
                shadow_d[w_idx] = &rgb_q;
            end
        end

        // Line end is folded in before the frame decision so a bad final
        // line still blocks a publish when both syncs fall together.
        w_line_bad  = (state_q == CAPTURE) && line_seen_q && w_hs_fall &&
                      (({1'b0, col_q} + 1'b1) != TOTAL_COL);
        w_err_line  = err_q | w_line_bad;
        w_frame_bad = ({1'b0, row_q} + 1'b1) != TOTAL_ROW;
        err_d       = w_err_line;

        if (w_vs_fall) begin
            if (state_q == ACQUIRE) begin
                state_d = CAPTURE;
            end else if (w_err_line || w_frame_bad) begin
                sync_error_d = 1'b1;
            end else begin
                grid_d        = shadow_q;
                frame_valid_d = 1'b1;
                sync_error_d  = 1'b0;
                locked_d      = 1'b1;
            end
            err_d    = 1'b0;
            shadow_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            next_col_q    <= COL_FIRST;
            next_row_q    <= ROW_FIRST;
            x_q           <= '0;
            y_q           <= '0;
            vs_pend_q     <= 1'b0;
            line_seen_q   <= 1'b0;
            err_q         <= 1'b0;
            state_q       <= ACQUIRE;
            shadow_q      <= '0;
            grid_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_error_q  <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            col_q         <= col_d;
            row_q         <= row_d;
            next_col_q    <= next_col_d;
            next_row_q    <= next_row_d;
            x_q           <= x_d;
            y_q           <= y_d;
            vs_pend_q     <= vs_pend_d;
            line_seen_q   <= line_seen_d;
            err_q         <= err_d;
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            grid_q        <= grid_d;
            frame_valid_q <= frame_valid_d;
            sync_error_q  <= sync_error_d;
            locked_q      <= locked_d;
        end
    end

    assign state_out   = grid_q;
    assign frame_valid = frame_valid_q;
    assign sync_error  = sync_error_q;
    assign locked      = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_grid_capture
//  Description : Directed bench for vga_grid_capture on a reduced 6x6 display
//                with 2-pixel cells (3x3 grid). A behavioural VGA source draws
//                cell patterns; expected grids are hand-written constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_grid_capture;

    localparam int DW = 6;
    localparam int DH = 6;
    localparam int SW = 2;
    localparam int MX = 3;
    localparam int MY = 3;
    localparam int NC = MX * MY;
    localparam int TC = DW + 160;
    localparam int TR = DH + 45;
    localparam int HV = 144;
    localparam int VV = 35;

    // Cell colour codes used by the source model.
    localparam int C_BLACK  = 0;
    localparam int C_WHITE  = 1;
    localparam int C_GREY   = 2;
    localparam int C_YELLOW = 3;

    localparam int P_GLIDER = 0;
    localparam int P_MIXED  = 1;
    localparam int P_DIAG   = 2;

    // Expected grids, index 0 leftmost: bit y*3+x.
    // Glider (1,0),(2,1),(0,2),(1,2),(2,2) -> bits 1,5,6,7,8.
    localparam logic [0:NC-1] EXP_GLIDER = 9'b010001111;
    // Mixed: white (2,0),(0,2); grey (1,1); yellow (0,0) -> bits 2,6.
    localparam logic [0:NC-1] EXP_MIXED  = 9'b001000100;
    // Diag: white (1,1),(2,2) -> bits 4,8.
    localparam logic [0:NC-1] EXP_DIAG   = 9'b000010001;

    logic              clk = 1'b0;
    logic              rst;
    logic              hsync;
    logic              vsync;
    logic [3:0]        r_in;
    logic [3:0]        g_in;
    logic [3:0]        b_in;
    logic [0:NC-1]     state_out;
    logic              frame_valid;
    logic              sync_error;
    logic              locked;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                fv_count = 0;
    int                grid [NC];
    logic              border;

    vga_grid_capture #(
        .DISPLAY_WIDTH  (DW),
        .DISPLAY_HEIGHT (DH),
        .S_WIDTH        (SW),
        .MAX_X          (MX),
        .MAX_Y          (MY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .state_out   (state_out),
        .frame_valid (frame_valid),
        .sync_error  (sync_error),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load_pattern(input int which);
        for (int i = 0; i < NC; i++) begin
            grid[i] = C_BLACK;
        end
        border = 1'b0;
        case (which)
            P_GLIDER: begin
                grid[1] = C_WHITE; grid[5] = C_WHITE;
                grid[6] = C_WHITE; grid[7] = C_WHITE; grid[8] = C_WHITE;
            end
            P_MIXED: begin
                grid[0] = C_YELLOW; grid[2] = C_WHITE;
                grid[4] = C_GREY;   grid[6] = C_WHITE;
                border  = 1'b1;
            end
            default: begin
                grid[4] = C_WHITE; grid[8] = C_WHITE;
            end
        endcase
    endtask

    // Colour of active pixel (px,py); black outside the active area.
    // With the border on, every pixel on a cell edge row/column is white.
    function automatic logic [11:0] pix(input int px, input int py);
        if (px < 0 || px >= DW || py < 0 || py >= DH) begin
            return 12'h000;
        end
        if (border && ((px % SW) == 0 || (py % SW) == 0)) begin
            return 12'hFFF;
        end
        case (grid[(py / SW) * MX + (px / SW)])
            C_WHITE:  return 12'hFFF;
            C_GREY:   return 12'h444;
            C_YELLOW: return 12'hFF0;
            default:  return 12'h000;
        endcase
    endfunction

    // Drive source lines v_first..v_last-1 of a frame. Line short_row is one
    // cycle short; rst pulses for 3 cycles at the start of line rst_row.
    task automatic send_rows(input int v_first, input int v_last,
                             input int short_row, input int rst_row);
        for (int v = v_first; v < v_last; v++) begin
            int len;
            len = (v == short_row) ? TC - 1 : TC;
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                hsync = (h >= 96);
                vsync = (v >= 2);
                {r_in, g_in, b_in} = pix(h - HV - 1, v - VV);
                rst = (v == rst_row) && (h < 3);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        r_in  = 4'h0;
        g_in  = 4'h0;
        b_in  = 4'h0;
        load_pattern(P_GLIDER);

        repeat (5) @(negedge clk);
        check_val("rst_state_out",   state_out,   '0);
        check_val("rst_frame_valid", frame_valid, 0);
        check_val("rst_sync_error",  sync_error,  0);
        check_val("rst_locked",      locked,      0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // F1: first vsync fall only arms capture.
        send_rows(0, TR, -1, -1);
        check_val("f1_fv_count",   fv_count,   0);
        check_val("f1_locked",     locked,     0);
        check_val("f1_sync_error", sync_error, 0);

        // F2: F1 glider published.
        load_pattern(P_MIXED);
        send_rows(0, TR, -1, -1);
        check_val("f2_fv_count",   fv_count,   1);
        check_val("f2_state_out",  state_out,  EXP_GLIDER);
        check_val("f2_locked",     locked,     1);
        check_val("f2_sync_error", sync_error, 0);

        // F3 (short line): F2 mixed pattern published.
        load_pattern(P_DIAG);
        send_rows(0, TR, 10, -1);
        check_val("f3_fv_count",    fv_count,     2);
        check_val("f3_state_out",   state_out,    EXP_MIXED);
        check_val("f3_preview_bit", state_out[4], 0);
        check_val("f3_sync_error",  sync_error,   0);

        // F4: F3 rejected, output held.
        send_rows(0, TR, -1, -1);
        check_val("f4_sync_error", sync_error, 1);
        check_val("f4_fv_count",   fv_count,   2);
        check_val("f4_state_out",  state_out,  EXP_MIXED);

        // F5 (one line too many): clean F4 published, error cleared.
        send_rows(0, TR + 1, -1, -1);
        check_val("f5_sync_error", sync_error, 0);
        check_val("f5_fv_count",   fv_count,   3);
        check_val("f5_state_out",  state_out,  EXP_DIAG);

        // F6: long F5 rejected.
        load_pattern(P_GLIDER);
        send_rows(0, TR, -1, -1);
        check_val("f6_sync_error", sync_error, 1);
        check_val("f6_fv_count",   fv_count,   3);
        check_val("f6_state_out",  state_out,  EXP_DIAG);
        check_val("f6_locked",     locked,     1);

        // F7: clean F6 published, then reset mid-frame.
        send_rows(0, 10, -1, -1);
        check_val("f7_sync_error", sync_error, 0);
        check_val("f7_fv_count",   fv_count,   4);
        check_val("f7_state_out",  state_out,  EXP_GLIDER);
        send_rows(10, TR, -1, 20);
        check_val("f7r_state_out", state_out,  '0);
        check_val("f7r_locked",    locked,     0);
        check_val("f7r_fv_count",  fv_count,   4);

        // F8: first full frame after reset only re-arms capture.
        send_rows(0, TR, -1, -1);
        check_val("f8_fv_count",  fv_count,  4);
        check_val("f8_state_out", state_out, '0);
        check_val("f8_locked",    locked,    0);

        // Start of F9 publishes F8.
        send_rows(0, 2, -1, -1);
        repeat (4) @(negedge clk);
        check_val("f9_fv_count",   fv_count,   5);
        check_val("f9_state_out",  state_out,  EXP_GLIDER);
        check_val("f9_locked",     locked,     1);
        check_val("f9_sync_error", sync_error, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_grid_capture.md
VGA_GRID_CAPTURE -- requirements
Module: vga_grid_capture

Interface
REQ-001 SHALL have parameter DISPLAY_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter DISPLAY_HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter S_WIDTH, default 10: cell edge in pixels.
REQ-004 SHALL have parameter MAX_X, default DISPLAY_WIDTH/S_WIDTH (64): grid columns.
REQ-005 SHALL have parameter MAX_Y, default DISPLAY_HEIGHT/S_WIDTH (48): grid rows.
REQ-006 SHALL have port clk, input, 1: pixel clock, the same clock as the VGA source.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have ports hsync and vsync, input, 1 each: sync from the VGA source, low during the sync pulse.
REQ-009 SHALL have ports r_in, g_in and b_in, input, 4 each: pixel colour.
REQ-010 SHALL have port state_out, output, [0:MAX_X*MAX_Y-1]: recovered grid, bit y*MAX_X+x = cell (x,y) alive.
REQ-011 SHALL have port frame_valid, output, 1: one-cycle pulse when state_out updates.
REQ-012 SHALL have port sync_error, output, 1: last frame had bad timing.
REQ-013 SHALL have port locked, output, 1: at least one clean frame captured since reset.

Function
REQ-014 SHALL register hsync, vsync and RGB once at input; all timing below is in registered-input cycles.
REQ-015 SHALL restart col_cnt at 0 on the first cycle registered hsync is low after being high; otherwise col_cnt increments, saturating at 1023.
REQ-016 SHALL restart row_cnt at 0 on the hsync falling edge that coincides with, or follows, a vsync falling edge; otherwise row_cnt increments on each hsync falling edge.
REQ-017 SHALL use TOTAL_COL = DISPLAY_WIDTH+160, TOTAL_ROW = DISPLAY_HEIGHT+45, H_VIDEO_BEGIN = 144 and V_VIDEO_BEGIN = 35.
REQ-018 SHALL treat pixel (px,py) as present at col_cnt = H_VIDEO_BEGIN+px+1 and row_cnt = V_VIDEO_BEGIN+py, because the source registers RGB one cycle after its counters.
REQ-019 SHALL sample each cell once, at px = x*S_WIDTH + S_WIDTH/2 and py = y*S_WIDTH + S_WIDTH/2.
REQ-020 SHALL record a cell as alive only when r_in, g_in and b_in are all 4'hF; any other value, including preview grey 4'h4, SHALL count as dead.
REQ-021 SHALL write samples into a shadow buffer and SHALL NOT change state_out mid-frame.
REQ-022 SHALL implement an FSM with states ACQUIRE and CAPTURE; reset SHALL enter ACQUIRE; the first vsync falling edge SHALL move ACQUIRE to CAPTURE.
REQ-023 SHALL set a frame error flag when any line ends (next hsync fall) with col_cnt+1 != TOTAL_COL.
REQ-024 SHALL also set the frame error flag when a frame ends (next vsync fall) with line count != TOTAL_ROW.
REQ-025 SHALL, at each vsync falling edge in CAPTURE, do the following when the flag is clear: copy shadow to state_out, pulse frame_valid one cycle later, clear sync_error and set locked.
REQ-026 SHALL, at each vsync falling edge in CAPTURE when the flag is set, do the following: set sync_error, hold state_out, suppress frame_valid and keep locked unchanged.
REQ-027 SHALL clear the frame error flag and the shadow buffer at every vsync falling edge.
REQ-028 SHALL, when hsync and vsync fall in the same cycle, evaluate line end before frame end.
REQ-029 SHALL NOT check the first partial line and frame after ACQUIRE.

Reset
REQ-030 SHALL, on rst, asynchronously clear state_out, the shadow buffer, both counters, frame_valid, sync_error, locked and the error flag, and enter ACQUIRE.
REQ-031 SHALL, on rst mid-frame, discard the partial frame; the next publish requires a full ACQUIRE-to-CAPTURE sequence.

Structure
REQ-032 SHALL take TOTAL_ROW, TOTAL_COL, H/V_VIDEO_BEGIN, MAX_X, MAX_Y and the idx(y,x) macro from the shared defines header also used by display.
REQ-033 SHALL instantiate one sub-module, sync_edge_det, for the register plus falling-edge detect, once each for hsync and vsync.

Verification
REQ-034 SHALL test reset: rst high for 5 cycles -> state_out=0, frame_valid=0, sync_error=0, locked=0.
REQ-035 SHALL test a display-driven glider: display at (1,0),(2,1),(0,2),(1,2),(2,2), 3 frames -> frame_valid once per frame after the first; bits 1, 66, 128, 129, 130 set, others 0.
REQ-036 SHALL test preview and border: preview grey at (10,10) and all-white border -> bit 650 = 0, no border-induced alive cells.
REQ-037 SHALL test a short line: one line shortened to 799 cycles -> sync_error=1, no frame_valid, state_out unchanged; the next clean frame clears sync_error.
REQ-038 SHALL test a long frame: 526 lines -> sync_error=1 for that frame only.
REQ-039 SHALL test reset mid-frame: rst at row 200 -> first frame_valid no earlier than the second full frame after release.
